// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / ISSUE / STALL)
//   - N_REQ_DEF   : default number of requesters
//   - RR_MAX      : largest supported requester count (fixed vector width of rr_pick)
//   - rr_pick     : round-robin pick, returns a one-hot vector of the winner
package fifo_wr_arbiter_pkg;

  localparam int          N_REQ_DEF = 4;
  localparam int unsigned RR_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Searches req[ptr], req[ptr+1], ... (wrapping at n) and returns the first
  // set position as a one-hot vector; all zeros when nothing is requested.
  // Requires ptr < n <= RR_MAX. Bits at or above n are always zero.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int unsigned       n);
    logic [RR_MAX-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin pick plus pointer register. Purely combinational pick from
//   the current pointer; the pointer moves to winner+1 only when the caller
//   signals that the pick was actually granted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request vector
//   advance    : the current pick is granted this cycle
//   gnt_oh     : one-hot pick (zero when req is zero)
//   winner     : binary index of the pick
//   any_req    : at least one request is set
//   ptr        : current round-robin start position
module rr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] winner,
  output logic             any_req,
  output logic [IDX_W-1:0] ptr
);

  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
  end

  assign pick    = rr_pick(req_ext, 3'(ptr), N_REQ);
  assign gnt_oh  = pick[N_REQ-1:0];
  assign any_req = |req;

  always_comb begin
    winner = '0;
    for (int i = 0; i < int'(RR_MAX); i++) begin
      if (pick[i]) winner = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any_req) begin
      ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the FIFO write port between N_REQ producers with round-robin
//   arbitration and full/almostfull backpressure, and routes each FIFO
//   wr_ack / overflow response back to the requester that issued the write.
//
// Handshake: a requester raises req[i] with stable req_data slice i and holds
//   both until it sees gnt[i] high while sampling; gnt is a combinational,
//   one-cycle pulse and the data is captured on that same clock edge. A
//   requester that keeps req high afterwards is simply arbitrated again.
//
// Ports:
//   clk, rst_n          : FIFO write clock, asynchronous active-low reset
//   req, req_data       : producer requests and packed data (slice i = requester i)
//   gnt                 : one-hot grant pulse
//   ack, ovf            : per-requester write acknowledge / overflow pulses
//   err_sticky          : set by any overflow, cleared only by reset
//   wr_cnt              : packed per-requester accepted-write counters
//   fifo_wr_en, fifo_data_in : registered FIFO write port
//   fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow : FIFO status
//   state, rr_ptr       : debug view of the FSM state and round-robin pointer
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int N_REQ      = N_REQ_DEF,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            ovf,
  output logic                        err_sticky,
  output logic [N_REQ*CNT_W-1:0]      wr_cnt,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output arb_state_e                  state,
  output logic [IDX_W-1:0]            rr_ptr
);

  // Reset asserts asynchronously everywhere but is released to the logic
  // only after two clean clock edges.
  logic [1:0] rst_sync;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ni = rst_sync[1];

  logic [N_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             can_issue;
  logic             issue;

  // Stop when full, and never follow a write with another while only one
  // slot was left: almostfull does not yet reflect the write in flight.
  assign can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  // Gated by the internal reset so no grant escapes while in reset.
  assign issue     = rst_ni && any_req && can_issue;
  assign gnt       = issue ? gnt_oh : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_ni),
    .req     (req),
    .advance (issue),
    .gnt_oh  (gnt_oh),
    .winner  (winner),
    .any_req (any_req),
    .ptr     (rr_ptr)
  );

  // Tag pipeline: tag1 travels with fifo_wr_en, tag2/rsp_vld line up with
  // the FIFO response one cycle later.
  logic [IDX_W-1:0] tag1;
  logic [IDX_W-1:0] tag2;
  logic             rsp_vld;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      tag1         <= '0;
      tag2         <= '0;
      rsp_vld      <= 1'b0;
      state        <= IDLE;
    end else begin
      fifo_wr_en <= issue;
      if (issue) begin
        fifo_data_in <= req_data[int'(winner)*FIFO_WIDTH +: FIFO_WIDTH];
        tag1         <= winner;
      end
      rsp_vld <= fifo_wr_en;
      tag2    <= tag1;

      case (state)
        IDLE: begin
          if (any_req) state <= can_issue ? ISSUE : STALL;
        end
        ISSUE: begin
          if (!any_req)        state <= IDLE;
          else if (!can_issue) state <= STALL;
        end
        STALL: begin
          if (!any_req)       state <= IDLE;
          else if (can_issue) state <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow takes precedence: a write that overflowed is not counted even
  // if wr_ack is also reported.
  always_comb begin
    ack = '0;
    ovf = '0;
    if (rsp_vld) begin
      if (fifo_overflow)    ovf[tag2] = 1'b1;
      else if (fifo_wr_ack) ack[tag2] = 1'b1;
    end
  end

  logic [CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      if (|ovf) err_sticky <= 1'b1;
      if (|ack) cnt_q[tag2] <= cnt_q[tag2] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign wr_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async-verification FIFO between N_REQ independent producers.
- Round-robin arbitration with full/almostfull backpressure; drives FIFO wr_en/data_in from registers.
- Attributes each FIFO wr_ack/overflow response back to the requester that issued the write.
- Sits between the producer agents and the FIFO DUT port; the FIFO read side is untouched.

Parameters:
- FIFO_WIDTH, 16, data width; must equal the FIFO's FIFO_WIDTH.
- N_REQ, 4, number of requesters, 2..8.
- CNT_W, 16, width of each per-requester accepted-write counter.

Ports:
- clk  input  1  FIFO write clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester write request; held until gnt.
- req_data  input  N_REQ*FIFO_WIDTH  packed data; slice i belongs to requester i; stable while req[i]=1.
- gnt  output  N_REQ  one-hot, one-cycle pulse: request i accepted, data captured this edge.
- ack  output  N_REQ  one-cycle pulse: FIFO confirmed requester i's write (wr_ack).
- ovf  output  N_REQ  one-cycle pulse: requester i's write hit FIFO overflow.
- err_sticky  output  1  set on any overflow; cleared only by reset.
- wr_cnt  output  N_REQ*CNT_W  accepted-write count per requester; wraps modulo 2^CNT_W.
- fifo_wr_en  output  1  registered FIFO write enable.
- fifo_data_in  output  FIFO_WIDTH  registered FIFO data.
- fifo_full  input  1  FIFO full.
- fifo_almostfull  input  1  FIFO one slot from full.
- fifo_wr_ack  input  1  FIFO write acknowledge, valid the cycle after fifo_wr_en.
- fifo_overflow  input  1  FIFO overflow, valid the cycle after fifo_wr_en.

Behaviour:
- Reset (async assert, sync deassert internally):
  - gnt, ack, ovf, fifo_wr_en, err_sticky, and all wr_cnt = 0.
  - fifo_data_in = 0; rr_ptr = 0; state = IDLE.
- FSM states: IDLE, ISSUE, STALL.
  - IDLE -> ISSUE when any req and can_issue.
  - IDLE -> STALL when any req and !can_issue.
  - ISSUE stays in ISSUE while requests remain and can_issue.
  - ISSUE -> STALL when !can_issue; ISSUE -> IDLE when no req.
  - STALL -> ISSUE when can_issue; STALL -> IDLE when no req.
- can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en).
  - Prevents two back-to-back writes into the last slot.
- Arbitration: search starts at rr_ptr and takes the first requester with req set.
  - The winner gets gnt for one cycle.
  - rr_ptr <= winner+1 mod N_REQ, only on a grant.
- Issue latency: gnt at cycle t; fifo_wr_en=1 and fifo_data_in=req_data[winner] during cycle t+1.
  - fifo_wr_en is a single cycle per grant; back-to-back grants give continuous wr_en.
  - A requester keeping req high after gnt is re-arbitrated normally, so it may be granted again next cycle if it is the only requester.
- Response tagging: the winner index is pipelined two stages alongside fifo_wr_en.
  - In cycle t+2: fifo_wr_ack=1 pulses ack[tag] and increments wr_cnt[tag].
  - In cycle t+2: fifo_overflow=1 pulses ovf[tag] and sets err_sticky.
  - Both high in the same cycle: ovf only, no ack, no count.
  - FIFO responses with no tagged write in flight are ignored.
- Boundaries:
  - full during ISSUE: no gnt that cycle; the in-flight write still completes and is tagged.
  - req withdrawn before gnt: legal; nothing is issued for it.
  - wr_cnt wraps at 2^CNT_W-1 -> 0.
  - Reset mid-operation: pending tags and in-flight fifo_wr_en are dropped immediately; no ack/ovf is produced for them.

Decomposition:
- Shared package FIFO_pkg gains:
  - typedef enum {IDLE, ISSUE, STALL} arb_state_e;
  - constant N_REQ_DEF;
  - function rr_pick(req, ptr) returning a one-hot vector.
- One sub-module, rr_arbiter: pure round-robin pick plus pointer register.
- Tag pipeline, FSM and counters stay in fifo_wr_arbiter.

Test Plan:
- Reset mid-stream: assert rst_n=0 during ISSUE -> all outputs 0 within the same cycle; no stray ack afterwards.
- Single requester: req=4'b0010, data 16'hA5A5, FIFO empty -> gnt=0010 at t, fifo_wr_en=1 with data A5A5 at t+1, ack=0010 at t+2, wr_cnt[1]=1.
- All four requesting continuously, FIFO empty -> grant order 0,1,2,3,0,...; each wr_cnt=2 after 8 grants; fifo_wr_en high for 8 consecutive cycles.
- almostfull asserted with fifo_wr_en=1 -> no gnt next cycle; state=STALL; resumes once almostfull drops (reader drains).
- fifo_full held high for 5 cycles with req=1111 -> gnt=0 throughout; rr_ptr unchanged; first grant after full drops goes to the prior rr_ptr.
- Forced fifo_overflow with fifo_wr_ack=0 on requester 2's write -> ovf=0100 at t+2; err_sticky=1 and stays 1 until reset; wr_cnt[2] unchanged.
